// File: rtl/chip8_debug_dumper_if.sv
// Debug-port request bus plus outgoing byte stream for chip8_debug_dumper.
// master = dumper side, slave = memory / stream consumer side.
interface chip8_debug_dumper_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 12,
    parameter int TYPE_W = 2
);
    logic [ADDR_W-1:0]  debug_addr_out;
    logic               debug_we_out;
    logic               debug_valid_out;
    logic [2*WIDTH-1:0] debug_data_out;
    logic [TYPE_W-1:0]  debug_type_out;
    logic               debug_size_out;
    logic               debug_ready_in;
    logic               debug_valid_in;
    logic [2*WIDTH-1:0] mem_data_in;
    logic [WIDTH-1:0]   byte_out;
    logic               byte_valid_out;
    logic               byte_ready_in;

    modport master (
        output debug_addr_out, debug_we_out, debug_valid_out, debug_data_out,
               debug_type_out, debug_size_out, byte_out, byte_valid_out,
        input  debug_ready_in, debug_valid_in, mem_data_in, byte_ready_in
    );

    modport slave (
        input  debug_addr_out, debug_we_out, debug_valid_out, debug_data_out,
               debug_type_out, debug_size_out, byte_out, byte_valid_out,
        output debug_ready_in, debug_valid_in, mem_data_in, byte_ready_in
    );
endinterface

// File: rtl/chip8_debug_dumper.sv
// Reads a block of bytes from one chip8_memory debug region, one request at a time,
// and streams them out on a valid/ready byte interface.
//
// state | meaning
// IDLE  | waiting for start_in
// REQ   | debug request presented, waiting for debug_ready_in
// WAIT  | request accepted, waiting for read data
// SEND  | byte held on the stream until accepted
// DRAIN | aborted with a response still owed; swallow it
module chip8_debug_dumper #(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 12,
    parameter int TYPE_W  = 2,
    parameter int MAX_LEN = 4096
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic [TYPE_W-1:0] start_type_in,
    input  logic [ADDR_W-1:0] start_addr_in,
    input  logic [12:0]       start_len_in,
    input  logic              abort_in,
    output logic              busy_out,
    output logic              done_out,
    chip8_debug_dumper_if.master bus
);
    localparam logic [12:0] MAX_LEN_V = 13'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SEND, S_DRAIN} state_t;

    state_t            state, state_d;
    logic              done_d;
    logic [TYPE_W-1:0] type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [12:0]       remaining;
    logic [WIDTH-1:0]  byte_q;
    logic              done_q;
    logic [12:0]       len_sat;
    logic              accept;
    logic              xfer;
    logic              unused_mem_hi;

    assign len_sat = (start_len_in > MAX_LEN_V) ? MAX_LEN_V : start_len_in;
    assign accept  = (state == S_REQ) && bus.debug_ready_in;
    assign xfer    = (state == S_SEND) && bus.byte_ready_in;

    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_in) begin
                    if (len_sat == 13'd0) done_d  = 1'b1;
                    else                  state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Abort on the accepting edge still leaves a response in flight.
                if (abort_in) begin
                    state_d = accept ? S_DRAIN : S_IDLE;
                    done_d  = !accept;
                end else if (accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort_in) begin
                    if (bus.debug_valid_in) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (bus.debug_valid_in) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (abort_in) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (xfer) begin
                    if (remaining == 13'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.debug_valid_in) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state     <= S_IDLE;
            done_q    <= 1'b0;
            type_q    <= '0;
            addr_q    <= '0;
            remaining <= '0;
            byte_q    <= '0;
        end else begin
            state  <= state_d;
            done_q <= done_d;
            if (state == S_IDLE && start_in) begin
                type_q    <= start_type_in;
                addr_q    <= start_addr_in;
                remaining <= len_sat;
            end
            if (state == S_WAIT && bus.debug_valid_in && !abort_in)
                byte_q <= bus.mem_data_in[WIDTH-1:0];
            if (xfer && !abort_in) begin
                remaining <= remaining - 13'd1;
                addr_q    <= addr_q + 1'b1;
            end
        end
    end

    assign busy_out            = (state != S_IDLE);
    assign done_out            = done_q;
    assign bus.debug_valid_out = (state == S_REQ);
    assign bus.debug_addr_out  = addr_q;
    assign bus.debug_type_out  = type_q;
    assign bus.debug_we_out    = 1'b0;
    assign bus.debug_data_out  = '0;
    assign bus.debug_size_out  = 1'b0;
    assign bus.byte_out        = byte_q;
    assign bus.byte_valid_out  = (state == S_SEND);
    assign unused_mem_hi       = ^bus.mem_data_in[2*WIDTH-1:WIDTH];
endmodule

// File: tb/tb_chip8_debug_dumper.sv
// Directed bench for chip8_debug_dumper: memory responder with programmable latency,
// stream/request loggers, a vector table of dumps and hand-written corner sequences.
module tb_chip8_debug_dumper;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  start_type = '0;
    logic [11:0] start_addr = '0;
    logic [12:0] start_len = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;

    chip8_debug_dumper_if bus ();

    chip8_debug_dumper dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .start_in      (start),
        .start_type_in (start_type),
        .start_addr_in (start_addr),
        .start_len_in  (start_len),
        .abort_in      (abort),
        .busy_out      (busy),
        .done_out      (done),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int lat = 1;
    int n_done = 0;
    int n_bv = 0;
    logic [11:0] req_addr[$];
    logic [1:0]  req_type[$];
    logic [7:0]  byte_log[$];

    typedef struct {
        logic [1:0]  t;
        logic [11:0] a;
        logic [12:0] len;
        int          lat;
        int          exp_n;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [7:0] mem_byte(input logic [1:0] t, input logic [11:0] a);
        return a[7:0] ^ {t, 6'h2A} ^ {4'h0, a[11:8]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_addr.delete();
        req_type.delete();
        byte_log.delete();
        n_done = 0;
        n_bv = 0;
    endtask

    task automatic start_dump(input logic [1:0] t, input logic [11:0] a, input logic [12:0] len);
        start_type = t;
        start_addr = a;
        start_len  = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && n_done == 0; i++) tick();
        check({tag, " done_seen"}, n_done, 1);
        tick();
        tick();
        check({tag, " busy_after"}, int'(busy), 0);
        check({tag, " done_once"}, n_done, 1);
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " dvalid"}, int'(bus.debug_valid_out), 0);
        check({tag, " daddr"}, int'(bus.debug_addr_out), 0);
        check({tag, " dtype"}, int'(bus.debug_type_out), 0);
        check({tag, " we"}, int'(bus.debug_we_out), 0);
        check({tag, " ddata"}, int'(bus.debug_data_out), 0);
        check({tag, " size"}, int'(bus.debug_size_out), 0);
        check({tag, " byte"}, int'(bus.byte_out), 0);
        check({tag, " bvalid"}, int'(bus.byte_valid_out), 0);
    endtask

    // Memory responder: logs each accepted request, answers after lat cycles.
    initial begin
        logic [11:0] a;
        logic [1:0]  t;
        bus.debug_valid_in = 1'b0;
        bus.mem_data_in    = '0;
        forever begin
            @(negedge clk);
            if (bus.debug_valid_out && bus.debug_ready_in) begin
                a = bus.debug_addr_out;
                t = bus.debug_type_out;
                req_addr.push_back(a);
                req_type.push_back(t);
                @(posedge clk);
                repeat (lat - 1) @(posedge clk);
                #1;
                bus.debug_valid_in = 1'b1;
                bus.mem_data_in    = {8'hC3, mem_byte(t, a)};
                @(posedge clk);
                #1;
                bus.debug_valid_in = 1'b0;
                bus.mem_data_in    = '0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (bus.byte_valid_out) n_bv++;
            if (bus.byte_valid_out && bus.byte_ready_in) byte_log.push_back(bus.byte_out);
        end
    end

    initial begin
        logic [11:0] ea;
        bus.debug_ready_in = 1'b1;
        bus.byte_ready_in  = 1'b1;

        vecs[0] = '{t: 2'd0, a: 12'h200, len: 13'd4,    lat: 3, exp_n: 4};
        vecs[1] = '{t: 2'd1, a: 12'hFFE, len: 13'd3,    lat: 1, exp_n: 3};
        vecs[2] = '{t: 2'd2, a: 12'h010, len: 13'd1,    lat: 2, exp_n: 1};
        vecs[3] = '{t: 2'd3, a: 12'h005, len: 13'd2,    lat: 5, exp_n: 2};
        vecs[4] = '{t: 2'd0, a: 12'h300, len: 13'd0,    lat: 1, exp_n: 0};
        vecs[5] = '{t: 2'd0, a: 12'h000, len: 13'd5000, lat: 1, exp_n: 4096};

        repeat (3) tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            lat = vecs[v].lat;
            clear_logs();
            start_dump(vecs[v].t, vecs[v].a, vecs[v].len);
            wait_done($sformatf("vec%0d", v), 30000);
            check($sformatf("vec%0d nbytes", v), byte_log.size(), vecs[v].exp_n);
            check($sformatf("vec%0d nreq", v), req_addr.size(), vecs[v].exp_n);
            for (int i = 0; i < vecs[v].exp_n; i++) begin
                ea = 12'(vecs[v].a + 12'(i));
                if (i < byte_log.size())
                    check($sformatf("vec%0d byte%0d", v, i), int'(byte_log[i]), int'(mem_byte(vecs[v].t, ea)));
                if (i < req_addr.size()) begin
                    check($sformatf("vec%0d addr%0d", v, i), int'(req_addr[i]), int'(ea));
                    check($sformatf("vec%0d type%0d", v, i), int'(req_type[i]), int'(vecs[v].t));
                end
            end
        end

        // len 0: done on the very next cycle, never busy
        clear_logs();
        start_dump(2'd1, 12'h123, 13'd0);
        @(negedge clk);
        check("len0 done_next", int'(done), 1);
        check("len0 busy", int'(busy), 0);
        tick();
        @(negedge clk);
        check("len0 done_pulse", int'(done), 0);

        // memory stalls in REQ, stream stalls in SEND, stray start while busy
        clear_logs();
        lat = 2;
        bus.debug_ready_in = 1'b0;
        bus.byte_ready_in  = 1'b0;
        start_dump(2'd0, 12'h050, 13'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall dvalid%0d", i), int'(bus.debug_valid_out), 1);
            check($sformatf("stall daddr%0d", i), int'(bus.debug_addr_out), 12'h050);
            start = (i == 2);
            start_addr = 12'h777;
            tick();
        end
        start = 1'b0;
        bus.debug_ready_in = 1'b1;
        for (int i = 0; i < 50 && !bus.byte_valid_out; i++) tick();
        check("stall bvalid_seen", int'(bus.byte_valid_out), 1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("hold byte%0d", i), int'(bus.byte_out), int'(mem_byte(2'd0, 12'h050)));
            check($sformatf("hold bvalid%0d", i), int'(bus.byte_valid_out), 1);
            check($sformatf("hold nreq%0d", i), req_addr.size(), 1);
            tick();
        end
        bus.byte_ready_in = 1'b1;
        wait_done("stall", 100);
        check("stall nbytes", byte_log.size(), 2);
        check("stall nreq", req_addr.size(), 2);
        if (req_addr.size() == 2) check("stall addr1", int'(req_addr[1]), 12'h051);
        if (byte_log.size() == 2) check("stall byte1", int'(byte_log[1]), int'(mem_byte(2'd0, 12'h051)));

        // abort in WAIT: done only after the owed response, no byte emitted
        clear_logs();
        lat = 6;
        start_dump(2'd0, 12'h100, 13'd2);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("abort busy_drain", int'(busy), 1);
        check("abort early_done", n_done, 0);
        tick();
        @(negedge clk);
        check("abort done_after_resp", int'(done), 1);
        tick();
        check("abort busy_after", int'(busy), 0);
        check("abort nbv", n_bv, 0);
        check("abort nreq", req_addr.size(), 1);
        clear_logs();
        lat = 2;
        start_dump(2'd2, 12'h040, 13'd2);
        wait_done("restart", 100);
        check("restart nbytes", byte_log.size(), 2);
        if (byte_log.size() == 2) check("restart byte0", int'(byte_log[0]), int'(mem_byte(2'd2, 12'h040)));

        // reset in WAIT followed by a stray response
        clear_logs();
        lat = 5;
        start_dump(2'd3, 12'h0AA, 13'd3);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_quiet("midrst");
        rst_n = 1'b1;
        repeat (8) tick();
        check("midrst nbv", n_bv, 0);
        check("midrst ndone", n_done, 0);
        check("midrst busy", int'(busy), 0);
        check("midrst nreq", req_addr.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
